rate_strobe_scheduler: RTL and testbench
========================================

Name: rate_strobe_scheduler

Overview:
- Single-clock controller that replaces a chain of ripple-clocked dividers with cascaded clock-enable strobes for the decimation stages of the FM receive chain (e.g. IF mixer -> CIC -> FIR -> audio).
- Each stage divides its parent's event rate by a programmable ratio.
- Ratios are reprogrammed through a valid/ready config port. A new ratio takes effect only at that stage's period boundary, so no stage ever sees a truncated period.

Parameters:
- N_STAGES, 3, number of cascaded strobe outputs (1..8).
- W, 16, ratio/counter width in bits.
- DEFAULT_RATIO, 2, ratio loaded into every stage at reset (1..2^W-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  enables counting. Low = counters cleared and held.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  config slot free.
- cfg_stage  input  $clog2(N_STAGES) (min 1)  stage index to reprogram.
- cfg_ratio  input  W  new divide ratio.
- cfg_err  output  1  one-cycle pulse: the accepted request had a bad stage index.
- stb  output  N_STAGES  per-stage clock-enable strobes, one clk cycle wide.
- pending  output  1  an accepted ratio change has not yet been applied.

Behaviour:
- Reset (async assert, sync use after release):
  - all counters = 0;
  - all ratios = DEFAULT_RATIO;
  - stb = 0, cfg_err = 0, pending = 0, cfg_ready = 1.
- Parent event for stage 0 = run. For stage k>0 = tick[k-1].
- tick[k] = parent event for stage k AND cnt[k] == ratio[k]-1. This is combinational and internal.
- Counter update on each edge where the parent event occurs:
  - if tick[k], cnt[k] <= 0;
  - otherwise cnt[k] <= cnt[k]+1.
- stb[k] is registered: stb[k] <= tick[k].
  - All active strobes of one edge coincide in the same cycle.
  - stb[k] implies stb[k-1].
- Latency: the first stb[0] is high in the cycle after the R0-th edge sampling run=1. Period of stb[k] = product of ratio[0..k] clk cycles.
- Ratio 1: stage k strobes on every parent event. Ratio 0 is written as 1.
- run low: on every edge, all cnt <= 0 and stb <= 0. When run returns, counting restarts from phase 0.
- Config handshake:
  - Accept when cfg_valid && cfg_ready.
  - cfg_ready = ~pending, so at most one change is outstanding.
  - cfg_valid may be held; the request is accepted on the first ready cycle.
- Accepted request with cfg_stage >= N_STAGES:
  - discarded;
  - cfg_err high for exactly the next cycle;
  - pending not set.
- Accepted request with a valid stage: stored in the pending slot, and pending = 1 from the next cycle.
- Apply rule:
  - On an edge where pending && (tick[s] || !run), ratio[s] <= stored ratio and pending <= 0.
  - The counter wraps to 0 normally, so the new period starts immediately.
  - The strobe from that wrap is still emitted under the old ratio.
  - cfg_ready returns high the cycle after application.
- An acceptance and an apply never occur on the same edge, because ready is low while pending.
- Counters are never compared against a ratio smaller than their current value mid-period. A ratio change therefore cannot cause wrap-around past 2^W.
- Reset mid-operation: pending requests are dropped and ratios return to DEFAULT_RATIO.

Test Plan:
1. Defaults, N_STAGES=3, DEFAULT_RATIO=2: release reset, run=1.
   - stb[0] every 2 cycles, stb[1] every 4, stb[2] every 8.
   - stb[2] cycles always coincide with stb[1] and stb[0].
2. Program stage 0 ratio 5 while cnt[0]=0: cfg accepted, pending=1.
   - The next stb[0] still arrives at the old period (2).
   - Thereafter stb[0] every 5 cycles, stb[1] every 10.
   - cfg_ready returns 1 the cycle after the apply.
3. Back-to-back requests with cfg_valid held:
   - the second request waits with cfg_ready=0 until the first applies;
   - both ratios end up in effect, none lost.
4. cfg_stage=3 with N_STAGES=3:
   - accepted, cfg_err single-cycle pulse;
   - ratios unchanged, pending stays 0.
5. Ratio 0 and 1 on stage 1:
   - with ratio 1, stb[1] equals stb[0] every strobe;
   - writing 0 gives identical behaviour.
6. Drop run mid-period with a change pending for stage 2:
   - stb goes 0 and counters clear;
   - the pending change applies on the next edge.
   - Assert async reset mid-count: outputs go to reset values without a clk edge, and ratios return to 2.

Source files
------------

// File: rtl/rate_strobe_scheduler.sv
// rate_strobe_scheduler
//
// Single-clock replacement for a chain of ripple-clocked dividers. Each stage
// counts its parent's events (stage 0's parent is run, stage k's parent is
// stage k-1's internal tick) and strobes once every ratio[k] parent events.
// Strobes are one-cycle clock enables; all strobes produced on one edge
// coincide in the following cycle.
//
// Ratios are reprogrammed through a single-slot config port. A new ratio is
// applied only on an edge where the target stage wraps (or while run is low),
// so a stage never sees a truncated period.
//
// Config handshake: a request transfers on a rising clk edge where
// cfg_valid && cfg_ready. cfg_valid may stay high while cfg_ready is low; the
// request then transfers on the first cycle cfg_ready is high. cfg_ready is
// simply ~pending, so at most one accepted change is outstanding.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   run        counting enable; low clears and holds all counters
//   cfg_valid  config request valid
//   cfg_ready  config slot free
//   cfg_stage  stage index to reprogram
//   cfg_ratio  new divide ratio (0 is stored as 1)
//   cfg_err    one-cycle pulse after accepting a request with a bad stage
//   stb        per-stage one-cycle clock-enable strobes
//   pending    an accepted ratio change has not yet been applied
module rate_strobe_scheduler #(
  parameter int N_STAGES      = 3,
  parameter int W             = 16,
  parameter int DEFAULT_RATIO = 2,
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [SW-1:0]       cfg_stage,
  input  logic [W-1:0]        cfg_ratio,
  output logic                cfg_err,
  output logic [N_STAGES-1:0] stb,
  output logic                pending
);

  logic [W-1:0]        cnt_q   [N_STAGES];
  logic [W-1:0]        cnt_d   [N_STAGES];
  logic [W-1:0]        ratio_q [N_STAGES];
  logic [W-1:0]        ratio_d [N_STAGES];
  logic [N_STAGES-1:0] stb_q, stb_d;
  logic                err_q, err_d;
  logic                pend_q, pend_d;
  logic [SW-1:0]       pstage_q, pstage_d;
  logic [W-1:0]        pratio_q, pratio_d;

  // par[k] is the parent event of stage k; par[k+1] is stage k's tick.
  logic [N_STAGES:0]   par;
  logic [N_STAGES-1:0] tick;
  logic                accept;
  logic                bad_stage;

  always_comb begin
    par[0] = run;
    for (int k = 0; k < N_STAGES; k++) begin
      tick[k]  = par[k] && (cnt_q[k] == ratio_q[k] - W'(1));
      par[k+1] = tick[k];
    end
  end

  assign accept    = cfg_valid && cfg_ready;
  assign bad_stage = (32'(cfg_stage) >= N_STAGES);

  always_comb begin
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    pend_d   = pend_q;
    pstage_d = pstage_q;
    pratio_d = pratio_q;
    err_d    = 1'b0;
    // tick is already all-zero while run is low.
    stb_d    = tick;

    for (int k = 0; k < N_STAGES; k++) begin
      if (!run || tick[k]) begin
        cnt_d[k] = '0;
      end else if (par[k]) begin
        cnt_d[k] = cnt_q[k] + W'(1);
      end
      // The stage's counter wraps to 0 on this same edge, so the new ratio
      // governs the very next period while this wrap's strobe used the old one.
      if (pend_q && (pstage_q == SW'(k)) && (tick[k] || !run)) begin
        ratio_d[k] = pratio_q;
        pend_d     = 1'b0;
      end
    end

    // Cannot coincide with an apply: cfg_ready is low whenever pend_q is set.
    if (accept) begin
      if (bad_stage) begin
        err_d = 1'b1;
      end else begin
        pend_d   = 1'b1;
        pstage_d = cfg_stage;
        pratio_d = (cfg_ratio == '0) ? W'(1) : cfg_ratio;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_STAGES; k++) begin
        cnt_q[k]   <= '0;
        ratio_q[k] <= W'(DEFAULT_RATIO);
      end
      stb_q    <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      pstage_q <= '0;
      pratio_q <= '0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        cnt_q[k]   <= cnt_d[k];
        ratio_q[k] <= ratio_d[k];
      end
      stb_q    <= stb_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      pstage_q <= pstage_d;
      pratio_q <= pratio_d;
    end
  end

  assign cfg_ready = ~pend_q;
  assign cfg_err   = err_q;
  assign stb       = stb_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_rate_strobe_scheduler.sv
// Testbench for rate_strobe_scheduler (N_STAGES=3, W=16, DEFAULT_RATIO=2).
// A reference model predicts every output each cycle: each stage holds the
// number of parent events still needed before its next strobe, and the config
// slot is tracked as a single pending request. Directed steps follow the test
// plan, with period measurements on top, then a randomized phase.
module tb_rate_strobe_scheduler;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int DR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_stage;
  logic [W-1:0]  cfg_ratio;
  logic          cfg_err;
  logic [N-1:0]  stb;
  logic          pending;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       rat_m  [N];
  int       left_m [N];
  bit       pend_m;
  int       ps_m;
  int       pr_m;
  bit [N-1:0] stb_m;
  bit       err_m;
  bit       last_acc;

  always #5 clk = ~clk;

  rate_strobe_scheduler #(.N_STAGES(N), .W(W), .DEFAULT_RATIO(DR)) dut (
    .clk(clk), .reset(reset), .run(run),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_stage(cfg_stage), .cfg_ratio(cfg_ratio),
    .cfg_err(cfg_err), .stb(stb), .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      rat_m[k]  = DR;
      left_m[k] = DR;
    end
    pend_m   = 0;
    ps_m     = 0;
    pr_m     = 0;
    stb_m    = '0;
    err_m    = 0;
    last_acc = 0;
  endtask

  // One clock edge of behaviour, using the inputs present at the edge.
  task automatic model_edge();
    bit         ev;
    bit [N-1:0] fire;
    bit         acc;
    acc  = cfg_valid && !pend_m;
    ev   = run;
    fire = '0;
    for (int k = 0; k < N; k++) begin
      if (!run) begin
        left_m[k] = rat_m[k];
      end else if (ev) begin
        if (left_m[k] == 1) begin
          fire[k]   = 1'b1;
          left_m[k] = rat_m[k];
        end else begin
          left_m[k] = left_m[k] - 1;
        end
      end
      ev = fire[k];
    end
    if (pend_m && (fire[ps_m] || !run)) begin
      rat_m[ps_m]  = pr_m;
      left_m[ps_m] = pr_m;
      pend_m       = 0;
    end
    err_m = 0;
    if (acc) begin
      if (int'(cfg_stage) >= N) begin
        err_m = 1;
      end else begin
        pend_m = 1;
        ps_m   = int'(cfg_stage);
        pr_m   = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
      end
    end
    stb_m    = fire;
    last_acc = acc;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    chk("stb",       32'(stb),       32'(stb_m));
    chk("cfg_err",   32'(cfg_err),   32'(err_m));
    chk("pending",   32'(pending),   32'(pend_m));
    chk("cfg_ready", 32'(cfg_ready), 32'(!pend_m));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a request and hold cfg_valid until it transfers.
  task automatic send_req(input logic [1:0] s, input logic [W-1:0] r);
    int n;
    cfg_valid = 1'b1;
    cfg_stage = s;
    cfg_ratio = r;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 500);
    chk("accept_within_bound", 32'(last_acc), 32'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_applied();
    int n;
    n = 0;
    while (pending === 1'b1 && n < 500) begin
      cycle();
      n++;
    end
    chk("apply_within_bound", 32'(pending), 32'd0);
  endtask

  // Cycles between two consecutive strobes of stage k.
  task automatic measure_period(input int k, input int exp, input string tag);
    int n;
    n = 0;
    while (stb[k] !== 1'b1 && n < 500) begin
      cycle();
      n++;
    end
    n = 0;
    do begin
      cycle();
      n++;
    end while (stb[k] !== 1'b1 && n < 500);
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int cnt2;
    reset     = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_stage = '0;
    cfg_ratio = '0;
    model_reset();

    // Reset values before any clock edge
    #1;
    chk("reset_stb",     32'(stb),       32'd0);
    chk("reset_err",     32'(cfg_err),   32'd0);
    chk("reset_pending", 32'(pending),   32'd0);
    chk("reset_ready",   32'(cfg_ready), 32'd1);
    cycle();
    reset = 1'b0;
    run   = 1'b1;

    // 1. Defaults: periods 2, 4, 8 with coincident strobes
    cnt2 = 0;
    for (int i = 0; i < 32; i++) begin
      cycle();
      if (stb[2] === 1'b1) begin
        cnt2++;
        chk("stb2_implies_lower", 32'(stb[1:0]), 32'd3);
      end
    end
    chk("stb2_count_32cyc", 32'(cnt2), 32'd4);
    measure_period(0, 2, "default_period0");
    measure_period(1, 4, "default_period1");
    measure_period(2, 8, "default_period2");

    // 2. Stage 0 -> 5, issued right after a stage-0 strobe (cnt[0]=0)
    while (stb[0] !== 1'b1) cycle();
    send_req(2'd0, 16'd5);
    chk("req0_pending", 32'(pending), 32'd1);
    wait_applied();
    measure_period(0, 5, "new_period0");
    measure_period(1, 10, "new_period1");

    // 3. Back-to-back with cfg_valid held across both requests
    send_req(2'd1, 16'd3);
    send_req(2'd2, 16'd2);
    wait_applied();
    measure_period(1, 15, "b2b_period1");
    measure_period(2, 30, "b2b_period2");

    // 4. Bad stage index
    send_req(2'd3, 16'd7);
    cycle();
    run_cycles(12);
    measure_period(0, 5, "after_bad_period0");

    // 5. Stage 1 ratio 1, then ratio 0
    send_req(2'd0, 16'd2);
    wait_applied();
    send_req(2'd1, 16'd1);
    wait_applied();
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("r1_stb1_eq_stb0", 32'(stb[1]), 32'(stb[0]));
    end
    send_req(2'd1, 16'd3);
    wait_applied();
    send_req(2'd1, 16'd0);
    wait_applied();
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("r0_stb1_eq_stb0", 32'(stb[1]), 32'(stb[0]));
    end

    // 6. Drop run with a stage-2 change pending
    run_cycles(3);
    send_req(2'd2, 16'd3);
    run = 1'b0;
    cycle();
    chk("runlow_stb",     32'(stb),     32'd0);
    chk("runlow_applied", 32'(pending), 32'd0);
    run_cycles(3);
    run = 1'b1;
    measure_period(2, 6, "restart_period2");

    // Async reset mid-count, between edges
    run_cycles(3);
    #2;
    reset = 1'b1;
    #1;
    chk("async_stb",     32'(stb),       32'd0);
    chk("async_err",     32'(cfg_err),   32'd0);
    chk("async_pending", 32'(pending),   32'd0);
    chk("async_ready",   32'(cfg_ready), 32'd1);
    model_reset();
    cycle();
    reset = 1'b0;
    measure_period(0, 2, "post_reset_period0");
    measure_period(2, 8, "post_reset_period2");

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      if (last_acc) cfg_valid = 1'b0;
      run = ($urandom_range(0, 15) != 0);
      if (!cfg_valid && $urandom_range(0, 5) == 0) begin
        cfg_valid = 1'b1;
        cfg_stage = 2'($urandom_range(0, 3));
        cfg_ratio = 16'($urandom_range(0, 4));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
